// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: one redirect per cycle (mem > ex > id) with combinational flush strobes.
// PC updates one cycle after request; stall/HALT hold the PC, and only mem-stage redirects are honoured while halted.
module pc_redirect_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_is_R7_pc,
    input  logic [15:0] ex_R7_pc,
    input  logic        mem_is_R7_pc,
    input  logic [15:0] mem_R7_pc,
    input  logic        id_is_jump,
    input  logic [15:0] id_jump_pc,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        resume,
    output logic [15:0] pc,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic        halted,
    output logic [15:0] redirect_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;
    logic        take_mem, take_ex, take_id, redirect;
    logic [15:0] target;

    always_comb begin
        // Older instruction wins; while halted only in-flight loads may still redirect.
        take_mem = mem_is_R7_pc;
        take_ex  = !mem_is_R7_pc && ex_is_R7_pc && (state_q == RUN);
        take_id  = !mem_is_R7_pc && !ex_is_R7_pc && id_is_jump && (state_q == RUN);
        redirect = take_mem || take_ex || take_id;

        target = 16'h0000;
        if (take_mem) begin
            target = mem_R7_pc;
        end else if (take_ex) begin
            target = ex_R7_pc;
        end else if (take_id) begin
            target = id_jump_pc;
        end

        state_d        = state_q;
        pc_d           = pc_q;
        redirect_cnt_d = redirect_cnt_q;

        if (redirect) begin
            pc_d = target;
            if (redirect_cnt_q != 16'hFFFF) begin
                redirect_cnt_d = redirect_cnt_q + 16'd1;
            end
        end else if ((state_q == RUN) && !stall && !halt_req) begin
            pc_d = pc_q + 16'd1;
        end

        if (state_q == RUN) begin
            if (halt_req && !redirect) begin
                state_d = HALT;
            end
        end else begin
            if (resume) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            pc_q           <= 16'h0000;
            redirect_cnt_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Strobes are gated by reset so they drop the instant reset asserts.
    assign flush_ifid   = reset_n && redirect;
    assign flush_idex   = reset_n && (take_mem || take_ex);
    assign flush_exmem  = reset_n && take_mem;

    assign pc           = pc_q;
    assign halted       = (state_q == HALT);
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        reset_n;
    logic        ex_is_R7_pc, mem_is_R7_pc, id_is_jump;
    logic [15:0] ex_R7_pc, mem_R7_pc, id_jump_pc;
    logic        stall, halt_req, resume;
    logic [15:0] pc, redirect_cnt;
    logic        flush_ifid, flush_idex, flush_exmem, halted;

    pc_redirect_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_is_R7_pc  (ex_is_R7_pc),
        .ex_R7_pc     (ex_R7_pc),
        .mem_is_R7_pc (mem_is_R7_pc),
        .mem_R7_pc    (mem_R7_pc),
        .id_is_jump   (id_is_jump),
        .id_jump_pc   (id_jump_pc),
        .stall        (stall),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .flush_exmem  (flush_exmem),
        .halted       (halted),
        .redirect_cnt (redirect_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  fl;   // {exmem, idex, ifid} during the request cycle
        logic [15:0] pc;   // after the edge
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // Reference state
    logic [15:0] m_pc;
    logic        m_halt;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 16'h0000;
        m_halt = 1'b0;
        m_cnt  = 16'h0000;
    endtask

    task automatic reset_checks();
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_cnt", {16'h0, redirect_cnt}, 32'h0);
        chk("rst_flush", {29'h0, flush_exmem, flush_idex, flush_ifid}, 32'h0);
    endtask

    // One cycle of stimulus; expectation follows directly from the stated rules.
    task automatic step(input logic mem, input logic [15:0] mt,
                        input logic ex,  input logic [15:0] et,
                        input logic id,  input logic [15:0] it,
                        input logic st,  input logic hr, input logic rs);
        exp_t        e;
        logic [15:0] tgt;
        logic        taken;
        @(negedge clk);
        mem_is_R7_pc = mem; mem_R7_pc = mt;
        ex_is_R7_pc  = ex;  ex_R7_pc  = et;
        id_is_jump   = id;  id_jump_pc = it;
        stall = st; halt_req = hr; resume = rs;

        taken = 1'b1;
        tgt   = 16'h0000;
        e.fl  = 3'b000;
        if (mem) begin
            e.fl = 3'b111; tgt = mt;
        end else if (!m_halt && ex) begin
            e.fl = 3'b011; tgt = et;
        end else if (!m_halt && id) begin
            e.fl = 3'b001; tgt = it;
        end else begin
            taken = 1'b0;
        end

        if (taken) begin
            m_pc  = tgt;
            m_cnt = (m_cnt == 16'hFFFF) ? 16'hFFFF : m_cnt + 16'd1;
        end else if (!m_halt && !hr && !st) begin
            m_pc = m_pc + 16'd1;
        end

        if (!m_halt) m_halt = hr && !taken;
        else         m_halt = !rs;

        e.pc = m_pc; e.halted = m_halt; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    endtask

    // Monitor: flushes sampled late in the request cycle, registers just after the edge.
    initial begin
        logic [2:0] fl_s;
        exp_t       e;
        forever begin
            @(negedge clk);
            #4;
            fl_s = {flush_exmem, flush_idex, flush_ifid};
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("flush", {29'h0, fl_s}, {29'h0, e.fl});
                chk("pc", {16'h0, pc}, {16'h0, e.pc});
                chk("halted", {31'h0, halted}, {31'h0, e.halted});
                chk("redirect_cnt", {16'h0, redirect_cnt}, {16'h0, e.cnt});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        mem_is_R7_pc = 0; mem_R7_pc = 0; ex_is_R7_pc = 0; ex_R7_pc = 0;
        id_is_jump = 0; id_jump_pc = 0; stall = 0; halt_req = 0; resume = 0;
        model_reset();
        #1;
        reset_checks();
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Idle counting from reset
        idle(); idle(); idle();

        // ex beats id in the same cycle
        step(0, 16'h0, 1, 16'h0010, 0, 16'h0, 0, 0, 0);
        step(0, 16'h0, 1, 16'h0040, 1, 16'h0080, 0, 0, 0);

        // Stall holds, mem redirect overrides stall
        step(1, 16'h0020, 0, 16'h0, 0, 16'h0, 0, 0, 0);
        step(0, 16'h0, 0, 16'h0, 0, 16'h0, 1, 0, 0);
        step(0, 16'h0, 0, 16'h0, 0, 16'h0, 1, 0, 0);
        step(1, 16'h1234, 0, 16'h0, 0, 16'h0, 1, 0, 0);

        // Halt, ignored ex/id while halted, mem drain, resume
        step(0, 16'h0, 1, 16'h0005, 0, 16'h0, 0, 0, 0);
        step(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 1, 0);
        step(0, 16'h0, 1, 16'h0777, 1, 16'h0888, 0, 0, 0);
        step(1, 16'h0100, 0, 16'h0, 0, 16'h0, 0, 0, 0);
        step(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
        idle(); idle();

        // halt_req with a redirect stays in RUN
        step(0, 16'h0, 0, 16'h0, 1, 16'h0300, 0, 1, 0);
        idle();

        // 16-bit wrap
        step(0, 16'h0, 1, 16'hFFFF, 0, 16'h0, 0, 0, 0);
        idle(); idle();

        // Counter saturation
        @(posedge clk);
        #2;
        force dut.redirect_cnt_q = 16'hFFFE;
        #1;
        release dut.redirect_cnt_q;
        m_cnt = 16'hFFFE;
        step(0, 16'h0, 0, 16'h0, 1, 16'h0200, 0, 0, 0);
        step(0, 16'h0, 0, 16'h0, 1, 16'h0300, 0, 0, 0);
        step(1, 16'h0400, 0, 16'h0, 0, 16'h0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 5) == 0, 16'($urandom),
                 $urandom_range(0, 4) == 0, 16'($urandom),
                 $urandom_range(0, 3) == 0, 16'($urandom),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0);
        end

        // Async reset in the middle of a redirect cycle
        step(1, 16'h4321, 1, 16'h1111, 1, 16'h2222, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        reset_checks();
        model_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(); idle();

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low; ports named clk and reset_n.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ex_is_R7_pc  input  1  Ex-stage R7 write (ADD/NDU/ADI/LHI) redirect request.
REQ-005 SHALL have ex_R7_pc  input  16  Ex-stage redirect target.
REQ-006 SHALL have mem_is_R7_pc  input  1  Mem-stage redirect request (LW/LM writing R7).
REQ-007 SHALL have mem_R7_pc  input  16  Mem-stage redirect target.
REQ-008 SHALL have id_is_jump  input  1  Decode-stage JAL/JLR redirect request.
REQ-009 SHALL have id_jump_pc  input  16  Decode-stage jump target.
REQ-010 SHALL have stall  input  1  hazard-unit hold request.
REQ-011 SHALL have halt_req  input  1  stop-fetch request; resume  input  1  restart request.
REQ-012 SHALL have pc  output  16  registered fetch address.
REQ-013 SHALL have flush_ifid, flush_idex, flush_exmem  output  1 each  combinational pipeline-register flush strobes.
REQ-014 SHALL have halted  output  1  high in HALT state; redirect_cnt  output  16  redirects taken.

Function
REQ-015 SHALL select one redirect per cycle by priority mem > ex > id (oldest instruction wins).
REQ-016 SHALL, on the selected redirect, load pc with its target at the next clk edge; no PC increment that cycle.
REQ-017 SHALL assert flush strobes in the same cycle as the redirect: mem -> all three; ex -> flush_ifid, flush_idex; id -> flush_ifid only; none otherwise.
REQ-018 SHALL, with no redirect, no stall, state RUN: pc <= pc + 1, 16-bit modulo (16'hFFFF -> 16'h0000).
REQ-019 SHALL hold pc when stall=1 and no redirect; a redirect overrides stall.
REQ-020 SHALL implement FSM states RUN and HALT only.
REQ-021 RUN -> HALT when halt_req=1 and no redirect that cycle; pc holds while entering and during HALT.
REQ-022 RUN with halt_req=1 and a redirect: redirect taken, state stays RUN; halt re-evaluated next cycle.
REQ-023 HALT -> RUN when resume=1; the first increment occurs on the edge after the transition edge.
REQ-024 SHALL, in HALT, accept only mem-stage redirects (drain of older in-flight loads): pc updates and flushes assert, state stays HALT; ex/id requests are ignored and produce no flushes.
REQ-025 SHALL increment redirect_cnt by 1 per taken redirect, saturating at 16'hFFFF.
REQ-026 SHALL ignore target inputs whose request bit is low.
REQ-027 halted SHALL equal (state == HALT), registered.

Reset
REQ-028 SHALL, with reset_n low, immediately force pc=16'h0000, state=RUN, halted=0, redirect_cnt=0.
REQ-029 Flush strobes SHALL be 0 during reset regardless of inputs.
REQ-030 Reset deassertion mid-operation: first increment on the first rising edge with reset_n high; no redirect state survives reset.

Verification
REQ-031 Reset, then 3 idle cycles -> pc sequence 0000, 0001, 0002, 0003; all flushes 0.
REQ-032 pc=0010, ex_is_R7_pc=1 ex_R7_pc=0040 and id_is_jump=1 id_jump_pc=0080 same cycle -> next pc=0040; flush_ifid=flush_idex=1, flush_exmem=0; redirect_cnt=1.
REQ-033 pc=0020, stall=1 two cycles, then mem_is_R7_pc=1 mem_R7_pc=1234 with stall=1 -> pc holds 0020 twice, then 1234; all three flushes high that cycle.
REQ-034 halt_req=1 at pc=0005 -> halted=1, pc stays 0005; ex redirect in HALT ignored (no flush); mem redirect to 0100 -> pc=0100, still HALT; resume=1 -> RUN, pc 0100 then 0101.
REQ-035 pc preloaded FFFF via redirect, idle -> pc=0000; redirect_cnt forced to FFFF then another redirect -> stays FFFF.
REQ-036 reset_n pulsed low mid-cycle during a redirect -> pc=0000, flushes 0 immediately, no clk edge required.
